pool_bram_ctrl: RTL and testbench

- Sequencer for the 6-input average-pool datapath: sum of six 8-bit samples, then right-shift by 3.
- Streams samples from an input BRAM with 1-cycle read latency and packs each group of 6 consecutive bytes into a window register.
- Presents the window on the datapath inputs, captures the pooled byte, and writes it to an output BRAM.
- Runs one job of n_win windows per start pulse; sits between the frame BRAMs and the pooling datapath.

---
 rtl/pool_bram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pool_bram_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_bram_ctrl.sv
// Sequencer for the 6-input average pool: streams bytes from an input BRAM, presents
// each 6-byte window to the datapath, writes the result out. Optional: POOL_MAX_EN adds max_val.
module pool_bram_ctrl #(
    parameter int IN_AW    = 10,
    parameter int OUT_AW   = 8,
    parameter int CNT_W    = 8,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_win,
    output logic              busy,
    output logic              done,
    output logic              in_en,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [7:0]        in_data,
    output logic [7:0]        ad0,
    output logic [7:0]        ad1,
    output logic [7:0]        ad2,
    output logic [7:0]        ad3,
    output logic [7:0]        ad4,
    output logic [7:0]        ad5,
    input  logic [7:0]        pool_in,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr,
    output logic [7:0]        out_data
`ifdef POOL_MAX_EN
    ,
    output logic [7:0]        max_val
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FILL, S_WRITE, S_DONE} state_t;

    localparam logic [IN_AW-1:0]  RD_ONE  = IN_AW'(1);
    localparam logic [OUT_AW-1:0] WR_ONE  = OUT_AW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [IN_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OUT_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]         k_q, k_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [47:0]        win_q, win_d;
    logic [CNT_W-1:0]   cnt_inc;
`ifdef POOL_MAX_EN
    logic [7:0]         max_q, max_d;
`endif

    assign cnt_inc = win_cnt_q + CNT_ONE;

    // Window is a byte shift register: the oldest sample drifts down to ad0.
    assign ad0 = win_q[7:0];
    assign ad1 = win_q[15:8];
    assign ad2 = win_q[23:16];
    assign ad3 = win_q[31:24];
    assign ad4 = win_q[39:32];
    assign ad5 = win_q[47:40];
`ifdef POOL_MAX_EN
    assign max_val = max_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            win_cnt_q <= '0;
            n_q       <= '0;
            win_q     <= '0;
`ifdef POOL_MAX_EN
            max_q     <= '0;
`endif
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            k_q       <= k_d;
            win_cnt_q <= win_cnt_d;
            n_q       <= n_d;
            win_q     <= win_d;
`ifdef POOL_MAX_EN
            max_q     <= max_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        k_d       = k_q;
        win_cnt_d = win_cnt_q;
        n_d       = n_q;
        win_d     = win_q;
`ifdef POOL_MAX_EN
        max_d     = max_q;
`endif
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        in_en     = 1'b0;
        in_addr   = rd_ptr_q;
        out_we    = 1'b0;
        out_addr  = wr_ptr_q;
        out_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef POOL_MAX_EN
                    max_d = '0;
`endif
                    if (n_win != '0) begin
                        n_d       = n_win;
                        rd_ptr_d  = IN_AW'(IN_BASE);
                        wr_ptr_d  = OUT_AW'(OUT_BASE);
                        k_d       = '0;
                        win_cnt_d = '0;
                        state_d   = S_READ;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_READ: begin
                in_en    = 1'b1;
                rd_ptr_d = rd_ptr_q + RD_ONE;
                // Read data lags the address by one cycle, so k=0 has nothing to capture yet.
                if (k_q != 3'd0) win_d = {in_data, win_q[47:8]};
                k_d = k_q + 3'd1;
                if (k_q == 3'd5) state_d = S_FILL;
            end
            S_FILL: begin
                win_d   = {in_data, win_q[47:8]};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                out_we    = 1'b1;
                out_data  = pool_in;
                wr_ptr_d  = wr_ptr_q + WR_ONE;
                win_cnt_d = cnt_inc;
`ifdef POOL_MAX_EN
                if (pool_in > max_q) max_d = pool_in;
`endif
                if (cnt_inc == n_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = '0;
                    state_d = S_READ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pool_bram_ctrl.sv
// Bench for pool_bram_ctrl: BRAM and pooling-datapath models around the DUT, directed and
// randomized jobs checked against a window-level reference model.
module tb_pool_bram_ctrl;

    localparam int IN_AW    = 10;
    localparam int OUT_AW   = 8;
    localparam int CNT_W    = 8;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 0;
    localparam int IN_SZ    = 1 << IN_AW;
    localparam int OUT_SZ   = 1 << OUT_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  n_win = '0;
    logic              busy, done, in_en, out_we;
    logic [IN_AW-1:0]  in_addr;
    logic [7:0]        in_data = 8'd0;
    logic [7:0]        ad0, ad1, ad2, ad3, ad4, ad5;
    logic [7:0]        pool_in;
    logic [OUT_AW-1:0] out_addr;
    logic [7:0]        out_data;
    logic [10:0]       psum;
`ifdef POOL_MAX_EN
    logic [7:0]        max_val;
`endif

    pool_bram_ctrl #(
        .IN_AW(IN_AW), .OUT_AW(OUT_AW), .CNT_W(CNT_W), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_win(n_win),
        .busy(busy), .done(done), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
        .ad0(ad0), .ad1(ad1), .ad2(ad2), .ad3(ad3), .ad4(ad4), .ad5(ad5),
        .pool_in(pool_in), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
`ifdef POOL_MAX_EN
        , .max_val(max_val)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: six-sample sum shifted right by three.
    assign psum    = 11'(ad0) + 11'(ad1) + 11'(ad2) + 11'(ad3) + 11'(ad4) + 11'(ad5);
    assign pool_in = psum[10:3];

    logic [7:0] mem [IN_SZ];
    always @(posedge clk) if (in_en) in_data <= mem[in_addr];

    typedef struct {int addr; int data; int cyc;} wr_t;
    int  acc_q[$], done_q[$], rd_q[$], rdc_q[$];
    wr_t wr_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;

    // Observe the cycle that is ending at each rising edge.
    always @(posedge clk) begin
        if (rst_n && start && !busy) acc_q.push_back(cyc);
        if (in_en) begin
            rd_q.push_back(int'(in_addr));
            rdc_q.push_back(cyc);
        end
        if (out_we) wr_q.push_back('{int'(out_addr), int'(out_data), cyc});
        if (done) done_q.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},      32'({busy, done, in_en, out_we}), 32'd0);
        chk({tag, "_in_addr"},  32'(in_addr), 32'd0);
        chk({tag, "_ad012"},    32'({ad0, ad1, ad2}), 32'd0);
        chk({tag, "_ad345"},    32'({ad3, ad4, ad5}), 32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    task automatic set_win(input int w, input int b [6]);
        for (int j = 0; j < 6; j++) mem[(IN_BASE + 6 * w + j) % IN_SZ] = 8'(b[j]);
    endtask

    function automatic int ref_pool(input int w);
        int s = 0;
        for (int j = 0; j < 6; j++) s += int'(mem[(IN_BASE + 6 * w + j) % IN_SZ]);
        return s / 8;
    endfunction

    task automatic clear_obs();
        acc_q.delete(); done_q.delete(); rd_q.delete(); rdc_q.delete(); wr_q.delete();
    endtask

    // One job: start, wait for done (bounded), then compare everything seen against the model.
    task automatic run_job(input string jt, input int n, input bit poke, input bit dstart);
        bit got = 0;
        int acc, bad, idx, ewa, emax;
        clear_obs();
        @(negedge clk);
        start = 1'b1; n_win = CNT_W'(n);
        @(negedge clk);
        start = 1'b0; n_win = CNT_W'($urandom);
        chk({jt, "_busy_after_start"}, 32'(busy), 32'd1);
`ifdef POOL_MAX_EN
        chk({jt, "_max_cleared"}, 32'(max_val), 32'd0);
`endif
        for (int i = 0; i < 8 * n + 20; i++) begin
            if (done) begin got = 1; break; end
            if (poke && i == 3) begin start = 1'b1; n_win = CNT_W'(7); end
            if (poke && i == 4) start = 1'b0;
            @(negedge clk);
        end
        if (!got) chk({jt, "_done_timeout"}, 32'd0, 32'd1);
        if (dstart) begin start = 1'b1; n_win = CNT_W'(2); end
        @(negedge clk);
        start = 1'b0;
        chk({jt, "_idle_busy"}, 32'(busy), 32'd0);
        chk({jt, "_accepts"}, 32'(acc_q.size()), 32'd1);
        chk({jt, "_done_pulses"}, 32'(done_q.size()), 32'd1);
        chk({jt, "_reads"}, 32'(rd_q.size()), 32'(6 * n));
        chk({jt, "_writes"}, 32'(wr_q.size()), 32'(n));
        if (acc_q.size() == 1 && done_q.size() == 1 && rd_q.size() == 6 * n && wr_q.size() == n) begin
            acc = acc_q[0];
            chk({jt, "_done_latency"}, 32'(done_q[0] - acc), 32'(8 * n + 1));
            if (n > 0) begin
                bad = -1;
                for (int i = 0; i < 6 * n; i++)
                    if (bad < 0 && (rd_q[i] != (IN_BASE + i) % IN_SZ ||
                                    rdc_q[i] != acc + 1 + 8 * (i / 6) + i % 6)) bad = i;
                idx = (bad >= 0) ? bad : 6 * n - 1;
                chk($sformatf("%s_rd%0d_addr", jt, idx), 32'(rd_q[idx]), 32'((IN_BASE + idx) % IN_SZ));
                chk($sformatf("%s_rd%0d_cyc", jt, idx), 32'(rdc_q[idx] - acc),
                    32'(1 + 8 * (idx / 6) + idx % 6));
                bad  = -1;
                emax = 0;
                for (int w = 0; w < n; w++) begin
                    ewa = (OUT_BASE + w) % OUT_SZ;
                    if (ref_pool(w) > emax) emax = ref_pool(w);
                    if (bad < 0 && (wr_q[w].addr != ewa || wr_q[w].data != ref_pool(w) ||
                                    wr_q[w].cyc != acc + 8 * (w + 1))) bad = w;
                end
                idx = (bad >= 0) ? bad : n - 1;
                chk($sformatf("%s_wr%0d_addr", jt, idx), 32'(wr_q[idx].addr), 32'((OUT_BASE + idx) % OUT_SZ));
                chk($sformatf("%s_wr%0d_data", jt, idx), 32'(wr_q[idx].data), 32'(ref_pool(idx)));
                chk($sformatf("%s_wr%0d_cyc", jt, idx), 32'(wr_q[idx].cyc - acc), 32'(8 * (idx + 1)));
`ifdef POOL_MAX_EN
                chk({jt, "_max_val"}, 32'(max_val), 32'(emax));
`endif
            end
        end
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < IN_SZ; i++) mem[i] = 8'($urandom);

        // Power-up reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single window of 8s: result 6, write 7 cycles after first read
        set_win(0, '{8, 8, 8, 8, 8, 8});
        run_job("single8", 1, 1'b0, 1'b0);
        if (wr_q.size() == 1) chk("single8_const", 32'(wr_q[0].data), 32'd6);

        // Largest possible sum
        set_win(0, '{255, 255, 255, 255, 255, 255});
        run_job("all255", 1, 1'b0, 1'b0);
        if (wr_q.size() == 1) chk("all255_const", 32'(wr_q[0].data), 32'd191);

        set_win(0, '{1, 2, 3, 4, 5, 6});
        run_job("ramp", 1, 1'b0, 1'b0);
        if (wr_q.size() == 1) chk("ramp_const", 32'(wr_q[0].data), 32'd2);

        // Three windows, with a stray start while busy
        set_win(0, '{8, 8, 8, 8, 8, 8});
        set_win(1, '{10, 10, 20, 20, 10, 10});
        set_win(2, '{0, 0, 0, 0, 0, 0});
        run_job("multi3", 3, 1'b1, 1'b0);
        if (wr_q.size() == 3) chk("multi3_const", 32'({wr_q[0].data[7:0], wr_q[1].data[7:0], wr_q[2].data[7:0]}),
                                  32'({8'd6, 8'd10, 8'd0}));

        // Empty job, plus a start raised while done is high (must be ignored)
        run_job("zero", 0, 1'b0, 1'b1);

        // Max tracking sequence: 6, 191, 10
        set_win(0, '{8, 8, 8, 8, 8, 8});
        set_win(1, '{255, 255, 255, 255, 255, 255});
        set_win(2, '{10, 10, 20, 20, 10, 10});
        run_job("maxseq", 3, 1'b0, 1'b0);

        // Randomized jobs; the long one wraps the input address
        for (int i = 0; i < IN_SZ; i++) mem[i] = 8'($urandom);
        run_job("rand5", 5, 1'b0, 1'b0);
        run_job("rand_short", int'($urandom_range(1, 12)), 1'b0, 1'b0);
        for (int i = 0; i < IN_SZ; i++) mem[i] = 8'($urandom);
        run_job("rand200", 200, 1'b0, 1'b0);

        // Reset during the third read of the second window
        clear_obs();
        @(negedge clk);
        start = 1'b1; n_win = CNT_W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_pre_in_en", 32'(in_en), 32'd1);
        chk("midrst_pre_in_addr", 32'(in_addr), 32'((IN_BASE + 8) % IN_SZ));
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_writes", 32'(wr_q.size()), 32'd1);
        chk("midrst_no_done", 32'(done_q.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        acc0 = acc_q.size();
        chk("midrst_accepts", 32'(acc0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
